multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multicycle control unit for the ARM-subset core; sits directly upstream of the condition logic.
- Decodes the latched instruction fields and sequences each instruction through fetch, decode, execute, memory and writeback.
- Produces the unconditional write requests pcs, reg_w, mem_w, flag_w and no_write, which the condition logic gates with cond_ex.
- Also drives the datapath mux selects, the ALU control and the IR/PC enables.
- Holds in memory states until a memory ready handshake completes.

Parameters:
- PC_REG, 4'd15, register index treated as the PC for pcs generation.

Ports:
- clk  input  1  single clock, all state on rising edge
- reset  input  1  synchronous, active-high
- op  input  2  instr[27:26]
- funct  input  6  instr[25:20]; [5]=I, [4:1]=cmd, [0]=S or L
- rd  input  4  instr[15:12]
- mem_ready  input  1  memory access completes this cycle
- pcs  output  1  PC write request to cond logic
- reg_w  output  1  register write request
- mem_w  output  1  memory write request
- flag_w  output  2  [1]=NZ write, [0]=CV write
- no_write  output  1  suppress register write (CMP)
- alu_control  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- ir_write  output  1  latch instruction register
- next_pc  output  1  unconditional PC+4 update
- adr_src  output  1  0=PC, 1=ALU result as memory address
- alu_src_a  output  1  0=reg A, 1=PC
- alu_src_b  output  2  00 reg B, 01 extended imm, 10 const 4
- result_src  output  2  00 ALUOut, 01 read data, 10 ALU result
- imm_src  output  2  equals op
- reg_src  output  2  {op==01, op==10}
- state  output  4  current state, for debug

Behaviour:
- State register updates on posedge clk. reset=1 forces state to FETCH on the next edge.
- While reset=1, all enables are forced to 0: ir_write, next_pc, pcs, reg_w, mem_w, flag_w, no_write.
- Outputs are combinational from state, op, funct, rd and mem_ready. There is no output register.
- Non-listed selects are 0 in every state.

States and outputs:
- FETCH: adr_src=0, alu_src_a=1, alu_src_b=10, result_src=10. ir_write and next_pc are asserted only when mem_ready=1. Goes to DECODE when mem_ready=1, else stays in FETCH.
- DECODE: alu_src_a=1, alu_src_b=10, result_src=10.
  - op=01 goes to MEMADR.
  - op=00 with funct[5]=0 goes to EXECR.
  - op=00 with funct[5]=1 goes to EXECI.
  - op=10 goes to BRANCH.
  - op=11 goes to FETCH and is treated as a NOP with no writes.
- MEMADR: alu_src_b=01, ALU add. funct[0]=1 goes to MEMRD, else MEMWR.
- MEMRD: adr_src=1. Stays until mem_ready, then goes to MEMWB.
- MEMWB: result_src=01, reg_w=1, then FETCH.
- MEMWR: adr_src=1. mem_w=1 on every cycle until mem_ready; on the mem_ready cycle it goes to FETCH.
- EXECR: alu_src_b=00, ALU decode active, then ALUWB.
- EXECI: alu_src_b=01, ALU decode active, then ALUWB.
- ALUWB: result_src=00, reg_w=1, then FETCH.
- BRANCH: alu_src_b=01, result_src=10, branch=1, then FETCH.

ALU decode (only in EXECR/EXECI/ALUWB; otherwise alu_control=00, flag_w=00, no_write=0):
- cmd 0100 gives ADD (00).
- cmd 0010 gives SUB (01).
- cmd 0000 gives AND (10).
- cmd 1100 gives ORR (11).
- cmd 1010 gives CMP: SUB (01) with no_write=1.
- Any other cmd gives 00 with flag_w=00.
- flag_w[1]=funct[0]. flag_w[0]=funct[0] & (ADD|SUB|CMP).
- flag_w is asserted only in EXECR/EXECI.
- no_write is held through ALUWB.

pcs:
- pcs = (reg_w & rd==PC_REG) | branch.

Latency:
- Load 5 states, store 4, data-processing 4, branch 3 cycles when mem_ready=1 at first sample.
- Each mem_ready=0 cycle adds one cycle.

Boundary conditions:
- mem_ready=1 in non-memory states is ignored.
- Reset mid-instruction returns to FETCH with no partial write asserted in the reset cycle.
- Op changes outside DECODE/MEMADR do not alter sequencing; only DECODE and MEMADR sample op/funct.

Decomposition:
- Package ctrl_pkg holds:
  - state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9
  - ALU control codes
  - cmd constants
  - src select constants
- One sub-module, alu_dec: purely combinational cmd/S to alu_control, flag_w, no_write.
- The FSM stays in multicycle_ctrl.

Test Plan:
- Reset: reset=1 for 2 cycles with mem_ready=1 → state=0, all enables 0. The cycle after release shows ir_write=1, next_pc=1.
- LDR (op=01, funct=011001), mem_ready=1 → states 0,1,2,3,4,0. reg_w=1 only in MEMWB, result_src=01.
- STR with mem_ready low 3 cycles in MEMWR → mem_w=1 for 4 cycles, then FETCH. reg_w=0 throughout.
- ADDS R15 register form (op=00, funct=001001, rd=15) → EXECR: alu_control=00, flag_w=11. ALUWB: reg_w=1, pcs=1.
- CMP immediate (funct=110101) → EXECI: alu_control=01, flag_w=11, no_write=1. ALUWB: no_write=1. Branch (op=10) → BRANCH: pcs=1, alu_src_b=01.
- FETCH stall: mem_ready=0 for 5 cycles → ir_write=0 and state=0 throughout. op=11 → DECODE then FETCH, with no enables asserted.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM states,
// ALU control codes, data-processing cmd values and mux select codes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/alu_dec.sv
// Combinational ALU decoder: cmd/S -> alu_control, flag_w, no_write.
// Ports: cmd, s, dec_en (decode active), flag_en (flag write allowed).
module alu_dec
    import ctrl_pkg::*;
(
    input  logic [3:0] cmd,
    input  logic       s,
    input  logic       dec_en,
    input  logic       flag_en,
    output logic [1:0] alu_control,
    output logic [1:0] flag_w,
    output logic       no_write
);

    logic known;
    logic arith;

    always_comb begin
        alu_control = ALU_ADD;
        no_write    = 1'b0;
        known       = 1'b0;
        arith       = 1'b0;
        if (dec_en) begin
            unique case (cmd)
                CMD_ADD: begin
                    alu_control = ALU_ADD;
                    known       = 1'b1;
                    arith       = 1'b1;
                end
                CMD_SUB: begin
                    alu_control = ALU_SUB;
                    known       = 1'b1;
                    arith       = 1'b1;
                end
                CMD_AND: begin
                    alu_control = ALU_AND;
                    known       = 1'b1;
                end
                CMD_ORR: begin
                    alu_control = ALU_ORR;
                    known       = 1'b1;
                end
                CMD_CMP: begin
                    alu_control = ALU_SUB;
                    no_write    = 1'b1;
                    known       = 1'b1;
                    arith       = 1'b1;
                end
                default: begin
                    alu_control = ALU_ADD;
                end
            endcase
        end
    end

    // Unrecognised commands never touch the flags, even with S set.
    assign flag_w = (flag_en && s && known) ? {1'b1, arith} : 2'b00;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle FSM controller: sequences fetch/decode/execute/mem/writeback,
// drives mux selects, ALU control, IR/PC enables and raw write requests.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter logic [3:0] PC_REG = 4'd15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    input  logic       mem_ready,
    output logic       pcs,
    output logic       reg_w,
    output logic       mem_w,
    output logic [1:0] flag_w,
    output logic       no_write,
    output logic [1:0] alu_control,
    output logic       ir_write,
    output logic       next_pc,
    output logic       adr_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic [1:0] reg_src,
    output logic [3:0] state
);

    state_t state_q;
    state_t state_d;

    logic       ir_raw;
    logic       npc_raw;
    logic       reg_w_raw;
    logic       mem_w_raw;
    logic       branch;
    logic       dec_en;
    logic       flag_en;
    logic [1:0] flag_raw;
    logic       nw_raw;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ir_raw     = 1'b0;
        npc_raw    = 1'b0;
        reg_w_raw  = 1'b0;
        mem_w_raw  = 1'b0;
        branch     = 1'b0;
        dec_en     = 1'b0;
        flag_en    = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        result_src = RES_ALUOUT;
        unique case (state_q)
            FETCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_raw     = mem_ready;
                npc_raw    = mem_ready;
                if (mem_ready) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                unique case (op)
                    OP_MEM:  state_d = MEMADR;
                    OP_DP:   state_d = funct[5] ? EXECI : EXECR;
                    OP_BR:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR: begin
                alu_src_b = SRCB_IMM;
                state_d   = funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                adr_src = 1'b1;
                if (mem_ready) begin
                    state_d = MEMWB;
                end
            end
            MEMWB: begin
                result_src = RES_RDATA;
                reg_w_raw  = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                adr_src   = 1'b1;
                mem_w_raw = 1'b1;
                if (mem_ready) begin
                    state_d = FETCH;
                end
            end
            EXECR: begin
                alu_src_b = SRCB_REG;
                dec_en    = 1'b1;
                flag_en   = 1'b1;
                state_d   = ALUWB;
            end
            EXECI: begin
                alu_src_b = SRCB_IMM;
                dec_en    = 1'b1;
                flag_en   = 1'b1;
                state_d   = ALUWB;
            end
            ALUWB: begin
                result_src = RES_ALUOUT;
                reg_w_raw  = 1'b1;
                dec_en     = 1'b1;
                state_d    = FETCH;
            end
            BRANCH: begin
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALU;
                branch     = 1'b1;
                state_d    = FETCH;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    alu_dec u_alu_dec (
        .cmd         (funct[4:1]),
        .s           (funct[0]),
        .dec_en      (dec_en),
        .flag_en     (flag_en),
        .alu_control (alu_control),
        .flag_w      (flag_raw),
        .no_write    (nw_raw)
    );

    // Enables are squashed during reset so no partial write escapes.
    assign ir_write = ir_raw & ~reset;
    assign next_pc  = npc_raw & ~reset;
    assign reg_w    = reg_w_raw & ~reset;
    assign mem_w    = mem_w_raw & ~reset;
    assign flag_w   = reset ? 2'b00 : flag_raw;
    assign no_write = nw_raw & ~reset;
    assign pcs      = ((reg_w_raw && rd == PC_REG) || branch) && !reset;

    assign imm_src = op;
    assign reg_src = {op == OP_MEM, op == OP_BR};
    assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: table of per-cycle vectors
// plus hand sequences for mid-instruction reset and late op changes.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       mem_ready;
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic [1:0] flag_w;
    logic       no_write;
    logic [1:0] alu_control;
    logic       ir_write;
    logic       next_pc;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic [3:0] state;

    int checks = 0;
    int failures = 0;

    multicycle_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .funct       (funct),
        .rd          (rd),
        .mem_ready   (mem_ready),
        .pcs         (pcs),
        .reg_w       (reg_w),
        .mem_w       (mem_w),
        .flag_w      (flag_w),
        .no_write    (no_write),
        .alu_control (alu_control),
        .ir_write    (ir_write),
        .next_pc     (next_pc),
        .adr_src     (adr_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .result_src  (result_src),
        .imm_src     (imm_src),
        .reg_src     (reg_src),
        .state       (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [3:0]  rd;
        logic        mr;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs[$];

    // en = {ir_write, next_pc, pcs, reg_w, mem_w}
    function automatic vec_t mk(
        input logic r, input logic [1:0] o, input logic [5:0] f,
        input logic [3:0] d, input logic mr, input logic [3:0] st,
        input logic [4:0] en, input logic [1:0] fw, input logic nw,
        input logic [1:0] alu, input logic adr, input logic a,
        input logic [1:0] b, input logic [1:0] res);
        vec_t v;
        v.r     = r;
        v.op    = o;
        v.funct = f;
        v.rd    = d;
        v.mr    = mr;
        v.exp   = {st, en, fw, nw, alu, adr, a, b, res};
        return v;
    endfunction

    function automatic logic [19:0] actual();
        return {state, ir_write, next_pc, pcs, reg_w, mem_w, flag_w,
                no_write, alu_control, adr_src, alu_src_a, alu_src_b,
                result_src};
    endfunction

    task automatic step(input logic r, input logic [1:0] o,
                        input logic [5:0] f, input logic [3:0] d,
                        input logic mr);
        @(posedge clk);
        #1;
        reset     = r;
        op        = o;
        funct     = f;
        rd        = d;
        mem_ready = mr;
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        reset     = 1'b1;
        op        = 2'b00;
        funct     = 6'b0;
        rd        = 4'd0;
        mem_ready = 1'b1;

        // reset, then LDR r3
        vecs.push_back(mk(1,2'b01,6'b011001,3,1, 0,5'b00000,2'b00,0,2'b00,0,1,2'b10,2'b10));
        vecs.push_back(mk(1,2'b01,6'b011001,3,1, 0,5'b00000,2'b00,0,2'b00,0,1,2'b10,2'b10));
        vecs.push_back(mk(0,2'b01,6'b011001,3,1, 0,5'b11000,2'b00,0,2'b00,0,1,2'b10,2'b10));
        vecs.push_back(mk(0,2'b01,6'b011001,3,1, 1,5'b00000,2'b00,0,2'b00,0,1,2'b10,2'b10));
        vecs.push_back(mk(0,2'b01,6'b011001,3,1, 2,5'b00000,2'b00,0,2'b00,0,0,2'b01,2'b00));
        vecs.push_back(mk(0,2'b01,6'b011001,3,1, 3,5'b00000,2'b00,0,2'b00,1,0,2'b00,2'b00));
        vecs.push_back(mk(0,2'b01,6'b011001,3,1, 4,5'b00010,2'b00,0,2'b00,0,0,2'b00,2'b01));
        // STR r2 with three wait cycles
        vecs.push_back(mk(0,2'b01,6'b011000,2,1, 0,5'b11000,2'b00,0,2'b00,0,1,2'b10,2'b10));
        vecs.push_back(mk(0,2'b01,6'b011000,2,1, 1,5'b00000,2'b00,0,2'b00,0,1,2'b10,2'b10));
        vecs.push_back(mk(0,2'b01,6'b011000,2,1, 2,5'b00000,2'b00,0,2'b00,0,0,2'b01,2'b00));
        vecs.push_back(mk(0,2'b01,6'b011000,2,0, 5,5'b00001,2'b00,0,2'b00,1,0,2'b00,2'b00));
        vecs.push_back(mk(0,2'b01,6'b011000,2,0, 5,5'b00001,2'b00,0,2'b00,1,0,2'b00,2'b00));
        vecs.push_back(mk(0,2'b01,6'b011000,2,0, 5,5'b00001,2'b00,0,2'b00,1,0,2'b00,2'b00));
        vecs.push_back(mk(0,2'b01,6'b011000,2,1, 5,5'b00001,2'b00,0,2'b00,1,0,2'b00,2'b00));
        // ADDS r15, register form
        vecs.push_back(mk(0,2'b00,6'b001001,15,1, 0,5'b11000,2'b00,0,2'b00,0,1,2'b10,2'b10));
        vecs.push_back(mk(0,2'b00,6'b001001,15,1, 1,5'b00000,2'b00,0,2'b00,0,1,2'b10,2'b10));
        vecs.push_back(mk(0,2'b00,6'b001001,15,1, 6,5'b00000,2'b11,0,2'b00,0,0,2'b00,2'b00));
        vecs.push_back(mk(0,2'b00,6'b001001,15,1, 8,5'b00110,2'b00,0,2'b00,0,0,2'b00,2'b00));
        // CMP immediate
        vecs.push_back(mk(0,2'b00,6'b110101,0,1, 0,5'b11000,2'b00,0,2'b00,0,1,2'b10,2'b10));
        vecs.push_back(mk(0,2'b00,6'b110101,0,1, 1,5'b00000,2'b00,0,2'b00,0,1,2'b10,2'b10));
        vecs.push_back(mk(0,2'b00,6'b110101,0,1, 7,5'b00000,2'b11,1,2'b01,0,0,2'b01,2'b00));
        vecs.push_back(mk(0,2'b00,6'b110101,0,1, 8,5'b00010,2'b00,1,2'b01,0,0,2'b00,2'b00));
        // branch
        vecs.push_back(mk(0,2'b10,6'b101000,0,1, 0,5'b11000,2'b00,0,2'b00,0,1,2'b10,2'b10));
        vecs.push_back(mk(0,2'b10,6'b101000,0,1, 1,5'b00000,2'b00,0,2'b00,0,1,2'b10,2'b10));
        vecs.push_back(mk(0,2'b10,6'b101000,0,1, 9,5'b00100,2'b00,0,2'b00,0,0,2'b01,2'b10));
        // fetch stall five cycles, then NOP (op=11)
        for (int i = 0; i < 5; i++) begin
            vecs.push_back(mk(0,2'b11,6'b000000,0,0, 0,5'b00000,2'b00,0,2'b00,0,1,2'b10,2'b10));
        end
        vecs.push_back(mk(0,2'b11,6'b000000,0,1, 0,5'b11000,2'b00,0,2'b00,0,1,2'b10,2'b10));
        vecs.push_back(mk(0,2'b11,6'b000000,0,1, 1,5'b00000,2'b00,0,2'b00,0,1,2'b10,2'b10));
        // SUB r1 without S
        vecs.push_back(mk(0,2'b00,6'b000100,1,1, 0,5'b11000,2'b00,0,2'b00,0,1,2'b10,2'b10));
        vecs.push_back(mk(0,2'b00,6'b000100,1,1, 1,5'b00000,2'b00,0,2'b00,0,1,2'b10,2'b10));
        vecs.push_back(mk(0,2'b00,6'b000100,1,1, 6,5'b00000,2'b00,0,2'b01,0,0,2'b00,2'b00));
        vecs.push_back(mk(0,2'b00,6'b000100,1,1, 8,5'b00010,2'b00,0,2'b01,0,0,2'b00,2'b00));
        // ORRS r4: logical op writes NZ only
        vecs.push_back(mk(0,2'b00,6'b011001,4,1, 0,5'b11000,2'b00,0,2'b00,0,1,2'b10,2'b10));
        vecs.push_back(mk(0,2'b00,6'b011001,4,1, 1,5'b00000,2'b00,0,2'b00,0,1,2'b10,2'b10));
        vecs.push_back(mk(0,2'b00,6'b011001,4,1, 6,5'b00000,2'b10,0,2'b11,0,0,2'b00,2'b00));
        vecs.push_back(mk(0,2'b00,6'b011001,4,1, 8,5'b00010,2'b00,0,2'b11,0,0,2'b00,2'b00));
        // unknown cmd 0111 with S: no flags, ADD code
        vecs.push_back(mk(0,2'b00,6'b001111,5,1, 0,5'b11000,2'b00,0,2'b00,0,1,2'b10,2'b10));
        vecs.push_back(mk(0,2'b00,6'b001111,5,1, 1,5'b00000,2'b00,0,2'b00,0,1,2'b10,2'b10));
        vecs.push_back(mk(0,2'b00,6'b001111,5,1, 6,5'b00000,2'b00,0,2'b00,0,0,2'b00,2'b00));
        vecs.push_back(mk(0,2'b00,6'b001111,5,1, 8,5'b00010,2'b00,0,2'b00,0,0,2'b00,2'b00));

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].op, vecs[i].funct, vecs[i].rd,
                 vecs[i].mr);
            chk($sformatf("vec%0d", i), 32'(actual()), 32'(vecs[i].exp));
        end

        // reset in the middle of a stalled store
        step(0, 2'b01, 6'b000000, 2, 1);
        chk("str_fetch", 32'(state), 32'd0);
        step(0, 2'b01, 6'b000000, 2, 1);
        step(0, 2'b01, 6'b000000, 2, 1);
        step(0, 2'b01, 6'b000000, 2, 0);
        chk("str_memwr_state", 32'(state), 32'd5);
        chk("str_memwr_mem_w", 32'(mem_w), 32'd1);
        step(1, 2'b01, 6'b000000, 2, 0);
        chk("rst_mid_mem_w", 32'(mem_w), 32'd0);
        chk("rst_mid_enables",
            32'({ir_write, next_pc, pcs, reg_w, flag_w, no_write}),
            32'd0);
        step(0, 2'b01, 6'b000000, 2, 0);
        chk("rst_mid_state", 32'(state), 32'd0);
        chk("rst_mid_ir", 32'(ir_write), 32'd0);

        // op/funct changes after MEMADR do not redirect the load
        step(0, 2'b01, 6'b000001, 3, 1);
        step(0, 2'b01, 6'b000001, 3, 1);
        step(0, 2'b01, 6'b000001, 3, 1);
        chk("ldr_memadr", 32'(state), 32'd2);
        step(0, 2'b10, 6'b000000, 15, 0);
        chk("ldr_memrd_hold", 32'(state), 32'd3);
        chk("imm_src", 32'(imm_src), 32'd2);
        chk("reg_src", 32'(reg_src), 32'd1);
        step(0, 2'b10, 6'b000000, 15, 1);
        chk("ldr_memrd_pcs", 32'(pcs), 32'd0);
        step(0, 2'b10, 6'b000000, 15, 1);
        chk("ldr_memwb_state", 32'(state), 32'd4);
        chk("ldr_memwb_pcs", 32'({reg_w, pcs}), 32'd3);
        step(0, 2'b01, 6'b000000, 0, 1);
        chk("ldr_back_fetch", 32'(state), 32'd0);
        chk("reg_src_mem", 32'(reg_src), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
